fpga_ss_loader: RTL and testbench



---
 rtl/fpga_ss_pkg.sv | 29 ++
 rtl/fpga_ss_loader_if.sv | 9 +
 rtl/fpga_ss_loader_sync2.sv | 19 +
 rtl/fpga_ss_loader.sv | 230 +++++++++++++++++++++++
 tb/tb_fpga_ss_loader.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fpga_ss_pkg.sv
// Shared types for the FPGA slave-serial loader: FSM encoding, error codes, word payload.
package fpga_ss_pkg;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned BIT_W  = $clog2(WORD_W);

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PROG,
        ST_WAIT_INIT,
        ST_LOAD,
        ST_SHIFT,
        ST_FLUSH,
        ST_OK,
        ST_ERR
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_INIT_TO = 2'd1;
    localparam logic [1:0] ERR_CRC     = 2'd2;

    // Rest states are the only ones where the loader is not working on a configuration.
    function automatic logic is_active(input state_t s);
        return !(s inside {ST_IDLE, ST_OK, ST_ERR});
    endfunction

endpackage

// File: rtl/fpga_ss_loader_if.sv
// Bitstream word stream from the FTDI receive path into the slave-serial loader.
interface fpga_ss_loader_if;
    fpga_ss_pkg::word_t word_data;
    logic               word_valid;
    logic               word_ready;

    modport master (output word_data, output word_valid, input word_ready);
    modport slave  (input word_data, input word_valid, output word_ready);
endinterface

// File: rtl/fpga_ss_loader_sync2.sv
// Two-flop synchronizer for the asynchronous FPGA status pins.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/fpga_ss_loader.sv
// Drives FPGA slave-serial configuration (PROGRAM_B, CCLK, DIN) from a 16-bit word stream.
// All pin and status outputs are registered.
module fpga_ss_loader
    import fpga_ss_pkg::*;
#(
    parameter int unsigned PROG_LOW_CYCLES = 64,
    parameter int unsigned CCLK_DIV        = 2,
    parameter int unsigned INIT_TIMEOUT    = 65535,
    parameter int unsigned DONE_EXTRA_CLKS = 16,
    parameter int unsigned CNT_W           = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    fpga_ss_loader_if.slave      word_if,
    input  logic                 fpga_init_b,
    input  logic                 fpga_done,
    output logic                 fpga_program_b,
    output logic                 fpga_bl_clk,
    output logic                 fpga_bl_data,
    output logic                 busy,
    output logic                 cfg_done,
    output logic                 cfg_error,
    output logic [1:0]           err_code,
    output logic [CNT_W-1:0]     words_loaded
);
    localparam int unsigned TMR_W = 32;
    localparam int unsigned DIV_W = $clog2(CCLK_DIV + 1);
    localparam int unsigned FL_W  = $clog2(DONE_EXTRA_CLKS + 1);

    logic init_b_sync, done_sync;

    sync2 u_init_sync (.clk(clk), .rst(rst), .d(fpga_init_b), .q(init_b_sync));
    sync2 u_done_sync (.clk(clk), .rst(rst), .d(fpga_done),   .q(done_sync));

    state_t            state_q, state_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [FL_W-1:0]   flush_q, flush_d;
    word_t             shreg_q, shreg_d;
    logic              program_b_q, program_b_d;
    logic              cclk_q, cclk_d;
    logic              din_q, din_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [1:0]        err_code_q, err_code_d;
    logic [CNT_W-1:0]  loaded_q, loaded_d;
    logic              phase_end;

    assign phase_end = (div_q == DIV_W'(CCLK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            tmr_q       <= '0;
            div_q       <= '0;
            bit_q       <= '0;
            flush_q     <= '0;
            shreg_q     <= '0;
            program_b_q <= 1'b1;
            cclk_q      <= 1'b0;
            din_q       <= 1'b0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            err_code_q  <= ERR_NONE;
            loaded_q    <= '0;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            flush_q     <= flush_d;
            shreg_q     <= shreg_d;
            program_b_q <= program_b_d;
            cclk_q      <= cclk_d;
            din_q       <= din_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            err_code_q  <= err_code_d;
            loaded_q    <= loaded_d;
        end
    end

    // Next-state and next-output logic; the CCLK divider toggles on each phase_end.
    always_comb begin
        state_d     = state_q;
        tmr_d       = tmr_q;
        div_d       = div_q;
        bit_d       = bit_q;
        flush_d     = flush_q;
        shreg_d     = shreg_q;
        program_b_d = program_b_q;
        cclk_d      = cclk_q;
        din_d       = din_q;
        ready_d     = 1'b0;
        done_d      = done_q;
        error_d     = error_q;
        err_code_d  = err_code_q;
        loaded_d    = loaded_q;

        case (state_q)
            ST_IDLE, ST_OK, ST_ERR: begin
                if (start) begin
                    state_d     = ST_PROG;
                    tmr_d       = '0;
                    program_b_d = 1'b0;
                    done_d      = 1'b0;
                    error_d     = 1'b0;
                    err_code_d  = ERR_NONE;
                    loaded_d    = '0;
                end
            end
            ST_PROG: begin
                if (tmr_q == TMR_W'(PROG_LOW_CYCLES - 1)) begin
                    state_d     = ST_WAIT_INIT;
                    tmr_d       = '0;
                    program_b_d = 1'b1;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            ST_WAIT_INIT: begin
                if (init_b_sync) begin
                    state_d = ST_LOAD;
                    ready_d = 1'b1;
                end else if (tmr_q == TMR_W'(INIT_TIMEOUT - 1)) begin
                    state_d    = ST_ERR;
                    error_d    = 1'b1;
                    err_code_d = ERR_INIT_TO;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            ST_LOAD, ST_SHIFT: begin
                if (!init_b_sync) begin
                    state_d    = ST_ERR;
                    error_d    = 1'b1;
                    err_code_d = ERR_CRC;
                    cclk_d     = 1'b0;
                    din_d      = 1'b0;
                end else if (state_q == ST_LOAD) begin
                    if (word_if.word_valid && ready_q) begin
                        state_d  = ST_SHIFT;
                        shreg_d  = word_if.word_data;
                        din_d    = word_if.word_data[WORD_W-1];
                        bit_d    = BIT_W'(WORD_W - 1);
                        div_d    = '0;
                        cclk_d   = 1'b0;
                        loaded_d = loaded_q + CNT_W'(1);
                    end else begin
                        ready_d = 1'b1;
                    end
                end else if (!phase_end) begin
                    div_d = div_q + DIV_W'(1);
                end else begin
                    div_d = '0;
                    if (!cclk_q) begin
                        cclk_d = 1'b1;
                    end else begin
                        cclk_d = 1'b0;
                        if (bit_q != '0) begin
                            bit_d = bit_q - BIT_W'(1);
                            din_d = shreg_q[bit_q - BIT_W'(1)];
                        end else if (done_sync) begin
                            state_d = ST_FLUSH;
                            din_d   = 1'b1;
                            flush_d = '0;
                        end else begin
                            state_d = ST_LOAD;
                            ready_d = 1'b1;
                        end
                    end
                end
            end
            ST_FLUSH: begin
                if (!phase_end) begin
                    div_d = div_q + DIV_W'(1);
                end else begin
                    div_d = '0;
                    if (!cclk_q) begin
                        cclk_d = 1'b1;
                    end else begin
                        cclk_d = 1'b0;
                        if (flush_q == FL_W'(DONE_EXTRA_CLKS - 1)) begin
                            state_d = ST_OK;
                            done_d  = 1'b1;
                            din_d   = 1'b0;
                        end else begin
                            flush_d = flush_q + FL_W'(1);
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort overrides everything, including a same-cycle start.
        if (abort) begin
            state_d     = ST_IDLE;
            program_b_d = 1'b1;
            cclk_d      = 1'b0;
            din_d       = 1'b0;
            ready_d     = 1'b0;
            done_d      = 1'b0;
            error_d     = 1'b0;
            err_code_d  = ERR_NONE;
        end

        busy_d = is_active(state_d);
    end

    assign word_if.word_ready = ready_q;
    assign fpga_program_b     = program_b_q;
    assign fpga_bl_clk        = cclk_q;
    assign fpga_bl_data       = din_q;
    assign busy               = busy_q;
    assign cfg_done           = done_q;
    assign cfg_error          = error_q;
    assign err_code           = err_code_q;
    assign words_loaded       = loaded_q;

endmodule

// File: tb/tb_fpga_ss_loader.sv
// Self-checking bench for fpga_ss_loader: DIN scoreboard sampled at CCLK rises plus directed corner cases.
module tb_fpga_ss_loader;

    localparam int unsigned CNT_W = 24;

    logic clk = 1'b0;
    logic rst, start, abort, fpga_init_b, fpga_done;
    logic fpga_program_b, fpga_bl_clk, fpga_bl_data, busy, cfg_done, cfg_error;
    logic [1:0] err_code;
    logic [CNT_W-1:0] words_loaded;

    fpga_ss_loader_if wif ();

    fpga_ss_loader #(
        .PROG_LOW_CYCLES(8), .CCLK_DIV(2), .INIT_TIMEOUT(100),
        .DONE_EXTRA_CLKS(16), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .word_if(wif.slave),
        .fpga_init_b(fpga_init_b), .fpga_done(fpga_done),
        .fpga_program_b(fpga_program_b), .fpga_bl_clk(fpga_bl_clk), .fpga_bl_data(fpga_bl_data),
        .busy(busy), .cfg_done(cfg_done), .cfg_error(cfg_error), .err_code(err_code),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Output bundle order: program_b, cclk, din, word_ready, busy, cfg_done, cfg_error, err_code[1:0]
    task automatic check_outs(input string name, input logic [8:0] exp);
        logic [8:0] act;
        act = {fpga_program_b, fpga_bl_clk, fpga_bl_data, wif.word_ready,
               busy, cfg_done, cfg_error, err_code};
        check(name, 32'(act), 32'(exp));
    endtask

    // Scoreboard of expected DIN at each CCLK rise, with expected spacing (0 = unchecked).
    typedef struct { logic din; int unsigned gap; } exp_bit_t;
    exp_bit_t sb_q[$];

    int unsigned cyc = 0;
    int unsigned last_rise = 0;
    int unsigned rises = 0;
    logic cclk_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : mon
        exp_bit_t e;
        if (fpga_bl_clk === 1'b1 && cclk_prev === 1'b0) begin
            rises++;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL cclk_rise: unexpected rise at cycle %0d, din=%0b", cyc, fpga_bl_data);
            end else begin
                e = sb_q.pop_front();
                check("din_at_rise", 32'(fpga_bl_data), 32'(e.din));
                if (e.gap != 0) check("rise_spacing", cyc - last_rise, e.gap);
            end
            last_rise = cyc;
        end
        cclk_prev = fpga_bl_clk;
    end

    task automatic push_bits(input logic [15:0] bits);
        for (int b = 15; b >= 0; b--) begin
            exp_bit_t e;
            e.din = bits[b];
            e.gap = (b == 15) ? 0 : 4;
            sb_q.push_back(e);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (wif.word_ready !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(wif.word_ready), 1);
    endtask

    // Present a word, wait for the handshake edge, and queue its expected serial bits.
    task automatic send_word(input logic [15:0] w, input logic [15:0] exp_bits);
        int n = 0;
        @(negedge clk);
        wif.word_data  = w;
        wif.word_valid = 1'b1;
        while (wif.word_ready !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("word_handshake", 32'(wif.word_ready), 1);
        push_bits(exp_bits);
        @(posedge clk);
        #1 wif.word_valid = 1'b0;
    endtask

    task automatic wait_rises(input int unsigned target);
        int n = 0;
        while (rises < target && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("rise_count", rises, target);
    endtask

    typedef struct { logic [15:0] word; logic [15:0] bits; int unsigned loaded; } vec_t;
    vec_t vecs[2];

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin : main
        int n;
        int unsigned base;
        int high_cnt;

        vecs[0] = '{word: 16'hAA99, bits: 16'b1010_1010_1001_1001, loaded: 1};
        vecs[1] = '{word: 16'h5566, bits: 16'b0101_0101_0110_0110, loaded: 2};

        rst = 1'b1; start = 1'b0; abort = 1'b0; fpga_init_b = 1'b0; fpga_done = 1'b0;
        wif.word_data = '0; wif.word_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_outs("reset_outputs", 9'b1_0_0_0_0_0_0_00);
        check("reset_words_loaded", 32'(words_loaded), 0);
        @(negedge clk) rst = 1'b0;

        // Full configuration: two words, then DONE and the flush clocks.
        pulse_start();
        n = 0;
        while (fpga_program_b === 1'b0 && n < 1000) begin
            n++;
            @(negedge clk);
        end
        check("program_b_low_cycles", n, 8);
        repeat (4) @(negedge clk);
        fpga_init_b = 1'b1;
        for (int i = 0; i < 2; i++) begin
            send_word(vecs[i].word, vecs[i].bits);
            check("words_loaded", 32'(words_loaded), vecs[i].loaded);
        end
        fpga_done = 1'b1;
        for (int k = 0; k < 16; k++) begin
            exp_bit_t e;
            e.din = 1'b1;
            e.gap = 4;
            sb_q.push_back(e);
        end
        n = 0;
        while (cfg_done !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check_outs("cfg_ok_outputs", 9'b1_0_0_0_0_1_0_00);
        check("final_words_loaded", 32'(words_loaded), 2);
        check("total_rises", rises, 48);
        check("scoreboard_empty", sb_q.size(), 0);

        // Word withheld in LOAD, then abort mid-shift.
        fpga_done = 1'b0;
        repeat (3) @(negedge clk);
        pulse_start();
        check("start_clears_done", 32'(cfg_done), 0);
        check("start_clears_count", 32'(words_loaded), 0);
        wait_ready("ready_after_init");
        base = rises;
        high_cnt = 0;
        repeat (50) begin
            @(negedge clk);
            if (fpga_bl_clk !== 1'b0) high_cnt++;
        end
        check("cclk_static_in_load", high_cnt, 0);
        check("busy_in_load", 32'(busy), 1);
        check("no_rise_in_load", rises, base);
        send_word(16'h1234, 16'b0001_0010_0011_0100);
        check("words_loaded_after_wait", 32'(words_loaded), 1);
        wait_rises(base + 6);
        @(negedge clk) abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check_outs("abort_outputs", 9'b1_0_0_0_0_0_0_00);
        sb_q.delete();
        base = rises;
        repeat (20) @(negedge clk);
        check("no_rise_after_abort", rises, base);

        // INIT_B never rises: timeout measured from PROGRAM_B release.
        fpga_init_b = 1'b0;
        repeat (3) @(negedge clk);
        pulse_start();
        n = 0;
        while (fpga_program_b !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        n = 0;
        while (cfg_error !== 1'b1 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("init_timeout_cycles", n, 100);
        check_outs("init_timeout_outputs", 9'b1_0_0_0_0_0_1_01);

        // INIT_B drops while bit 7 of a word is being shifted.
        fpga_init_b = 1'b1;
        repeat (3) @(negedge clk);
        pulse_start();
        wait_ready("ready_before_init_drop");
        base = rises;
        send_word(16'hF0F0, 16'b1111_0000_1111_0000);
        wait_rises(base + 8);
        fpga_init_b = 1'b0;
        n = 0;
        while (cfg_error !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("init_low_latency", n, 3);
        check_outs("init_low_outputs", 9'b1_0_0_0_0_0_1_10);
        check("init_low_rises", rises, base + 8);
        sb_q.delete();

        // Asynchronous reset in the middle of a word.
        fpga_init_b = 1'b1;
        repeat (3) @(negedge clk);
        pulse_start();
        wait_ready("ready_before_reset");
        base = rises;
        send_word(16'hC3A5, 16'b1100_0011_1010_0101);
        wait_rises(base + 3);
        #2 rst = 1'b1;
        #1;
        check_outs("async_reset_outputs", 9'b1_0_0_0_0_0_0_00);
        check("async_reset_count", 32'(words_loaded), 0);
        sb_q.delete();
        base = rises;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("no_rise_after_reset", rises, base);
        check_outs("idle_after_reset", 9'b1_0_0_0_0_0_0_00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
